// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for the conv engine.
// Two line buffers plus a 3x3 shift array; emits only unpadded windows.
module conv_window_gen #(
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_pixel,
  input  logic        i_pixel_valid,
  output logic [71:0] o_window,
  output logic        o_window_valid,
  output logic        o_frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef enum logic {
    FILL,
    STREAM
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];

  logic [7:0] win     [3][3];
  logic [7:0] win_nxt [3][3];
  logic [71:0] window_nxt;

  logic last_col;
  logic last_row;
  logic emit;
  logic frame_end;

  assign last_col = (col == CW'(IMG_WIDTH - 1));
  assign last_row = (row == RW'(IMG_HEIGHT - 1));

  // FILL covers rows 0/1 and the frame seam, so no window mixes frames
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    frame_end = 1'b0;
    if (i_pixel_valid) begin
      unique case (state)
        FILL: begin
          if (row == RW'(1) && last_col)
            state_nxt = STREAM;
        end
        STREAM: begin
          emit = (col >= CW'(2));
          if (last_row && last_col) begin
            frame_end = 1'b1;
            state_nxt = FILL;
          end
        end
      endcase
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_nxt[r][0] = win[r][1];
      win_nxt[r][1] = win[r][2];
    end
    win_nxt[0][2] = lb2[col];
    win_nxt[1][2] = lb1[col];
    win_nxt[2][2] = i_pixel;
    window_nxt = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        window_nxt[(r*3+c)*8 +: 8] = win_nxt[r][c];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= FILL;
      row            <= '0;
      col            <= '0;
      o_window       <= '0;
      o_window_valid <= 1'b0;
      o_frame_done   <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_window_valid <= emit;
      o_frame_done   <= frame_end;
      if (emit)
        o_window <= window_nxt;
      if (i_pixel_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Storage without reset: stale contents never reach an emitted window
  always_ff @(posedge i_clk) begin
    if (i_pixel_valid) begin
      lb2[col] <= lb1[col];
      lb1[col] <= i_pixel;
      win      <= win_nxt;
    end
  end

endmodule
